axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, meaning max cycles spent in any AXI wait state before abort; legal range 2..65535.
REQ-002 Parameter AXI_PROT, default 3'b000, meaning value driven on axi_awprot/axi_arprot (normal, secure, data).
REQ-003 axi_clk  in  1  single clock for all logic.
REQ-004 axi_rst  in  1  reset; synchronous, active-high.
REQ-005 cmd_valid in 1 / cmd_ready out 1: command handshake.
REQ-006 cmd_wr in 1 (1 write, 0 read); cmd_addr in 32; cmd_wdata in 32; cmd_wstrb in 4.
REQ-007 rsp_valid out 1 / rsp_ready in 1: response handshake.
REQ-008 rsp_rdata out 32; rsp_resp out 2 (AXI code); rsp_timeout out 1 (abort flag); rsp_wr out 1 (echo of cmd_wr).
REQ-009 Write address channel: axi_awaddr out 32, axi_awprot out 3, axi_awvalid out 1, axi_awready in 1.
REQ-010 Write data channel: axi_wdata out 32, axi_wstrb out 4, axi_wvalid out 1, axi_wready in 1.
REQ-011 Write response channel: axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.
REQ-012 Read channels: axi_araddr out 32, axi_arprot out 3, axi_arvalid out 1, axi_arready in 1, axi_rdata in 32, axi_rresp in 2, axi_rvalid in 1, axi_rready out 1.

Function
REQ-013 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; all outputs registered.
REQ-014 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid && cmd_ready, and cmd fields latched that cycle.
REQ-015 Write accept at cycle N -> WR_REQ; axi_awvalid and axi_wvalid both 1 at N+1 with latched addr/data/strb.
REQ-016 In WR_REQ, axi_awvalid SHALL drop the cycle after its own handshake and axi_wvalid likewise, independently; either order or same cycle is legal.
REQ-017 When both AW and W handshakes have completed -> WR_RESP with axi_bready=1; on axi_bvalid && axi_bready, capture axi_bresp, drop bready, go to DONE.
REQ-018 Read accept at cycle N -> RD_REQ; axi_arvalid=1 at N+1; on arready handshake drop arvalid, go to RD_RESP with axi_rready=1.
REQ-019 In RD_RESP, on axi_rvalid && axi_rready, capture axi_rdata and axi_rresp, drop rready, go to DONE.
REQ-020 Valid/address/data SHALL remain stable while valid is 1 and ready is 0.
REQ-021 DONE: rsp_valid=1 with rsp_rdata (0 for writes), rsp_resp, rsp_wr, rsp_timeout held stable until rsp_ready; then rsp_valid=0, state IDLE; back-to-back command accepted no earlier than the cycle after.
REQ-022 Timeout counter (16 bit) SHALL clear on entry to WR_REQ/RD_REQ and on each state change, increment each cycle in WR_REQ, WR_RESP, RD_REQ, RD_RESP; it SHALL saturate, never wrap.
REQ-023 On count == TIMEOUT_CYCLES-1 without completion: deassert all AXI valids/readies next cycle, go to DONE with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0 (hung-slave recovery only).
REQ-024 A handshake completing in the same cycle as the timeout SHALL win; no timeout reported.
REQ-025 Unexpected axi_bvalid/axi_rvalid outside WR_RESP/RD_RESP SHALL be ignored (ready stays 0).
REQ-026 axi_awprot/axi_arprot SHALL constantly equal AXI_PROT.

Reset
REQ-027 axi_rst=1 SHALL force IDLE in one cycle from any state, including mid-transaction; cmd_ready=1 the cycle after release.
REQ-028 Reset values: all AXI valid/ready outputs 0, addresses/data/strb 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0, rsp_wr 0, timeout counter 0.

Verification
REQ-029 Write 0x0000_0004 data 0xDEAD_BEEF strb 0xF, slave readies immediate, bresp 0 -> one AW and one W handshake with those values, rsp_valid with rsp_resp=0, rsp_timeout=0.
REQ-030 Read 0x0000_0020, slave returns rdata 0x1234_5678 rresp 0 after 3-cycle arready delay -> arvalid held stable 3 cycles, rsp_rdata=0x1234_5678.
REQ-031 Write with wready before awready (W at N+1, AW at N+4) -> wvalid drops after N+1, awvalid held to N+4, single B handshake, rsp once.
REQ-032 Read, slave never asserts arready, TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp fields stable, cmd_ready stays 0; next command accepted after release.
REQ-034 Reset asserted in WR_RESP -> all outputs at reset values next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master.
// Accepts one read or write command, runs it on the AXI-Lite channels and
// returns one response. A per-state cycle counter aborts transactions
// stuck on a hung slave.
module axi_lite_master #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [2:0] AXI_PROT       = 3'b000
) (
    input  logic        axi_clk,
    input  logic        axi_rst,

    // Command interface
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    // Response interface
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        rsp_wr,

    // Write address channel
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,

    // Write data channel
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,

    // Write response channel
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,

    // Read address channel
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,

    // Read data channel
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RESP_ERR = 2'b10;

    state_t      state, state_d;
    logic [15:0] wait_cnt, wait_cnt_d;
    logic        aw_done, aw_done_d;
    logic        w_done, w_done_d;

    logic        cmd_ready_d;
    logic        rsp_valid_d, rsp_timeout_d, rsp_wr_d;
    logic [31:0] rsp_rdata_d;
    logic [1:0]  rsp_resp_d;
    logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [31:0] awaddr_d, wdata_d, araddr_d;
    logic [3:0]  wstrb_d;

    logic        timeout_hit;
    logic        do_abort;
    logic        in_wait;

    assign axi_awprot = AXI_PROT;
    assign axi_arprot = AXI_PROT;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d       = state;
        aw_done_d     = aw_done;
        w_done_d      = w_done;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        rsp_wr_d      = rsp_wr;
        awvalid_d     = axi_awvalid;
        wvalid_d      = axi_wvalid;
        bready_d      = axi_bready;
        arvalid_d     = axi_arvalid;
        rready_d      = axi_rready;
        awaddr_d      = axi_awaddr;
        wdata_d       = axi_wdata;
        wstrb_d       = axi_wstrb;
        araddr_d      = axi_araddr;
        do_abort      = 1'b0;
        timeout_hit   = (wait_cnt == TO_LAST);

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rsp_wr_d = cmd_wr;
                    if (cmd_wr) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end

            WR_REQ: begin
                // AW and W complete independently, in either order.
                if (axi_awvalid && axi_awready) awvalid_d = 1'b0;
                if (axi_wvalid && axi_wready)   wvalid_d  = 1'b0;
                aw_done_d = aw_done | (axi_awvalid & axi_awready);
                w_done_d  = w_done  | (axi_wvalid  & axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    do_abort = 1'b1;
                end
            end

            WR_RESP: begin
                if (axi_bvalid && axi_bready) begin
                    state_d       = DONE;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi_bresp;
                    rsp_rdata_d   = 32'h0;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    do_abort = 1'b1;
                end
            end

            RD_REQ: begin
                if (axi_arvalid && axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout_hit) begin
                    do_abort = 1'b1;
                end
            end

            RD_RESP: begin
                if (axi_rvalid && axi_rready) begin
                    state_d       = DONE;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi_rresp;
                    rsp_rdata_d   = axi_rdata;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    do_abort = 1'b1;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase

        // Hung-slave recovery: drop every valid/ready and report an error.
        if (do_abort) begin
            state_d       = DONE;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_ERR;
            rsp_rdata_d   = 32'h0;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    // Wait counter: restarts on every state change, saturates at all-ones.
    always_comb begin
        in_wait    = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
        wait_cnt_d = wait_cnt;
        if (state_d != state) begin
            wait_cnt_d = 16'h0;
        end else if (in_wait && (wait_cnt != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge axi_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (axi_rst) begin
            state       <= IDLE;
            wait_cnt    <= 16'h0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            rsp_wr      <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= 32'h0;
            axi_wdata   <= 32'h0;
            axi_wstrb   <= 4'h0;
            axi_araddr  <= 32'h0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            aw_done     <= aw_done_d;
            w_done      <= w_done_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_wr      <= rsp_wr_d;
            axi_awvalid <= awvalid_d;
            axi_wvalid  <= wvalid_d;
            axi_bready  <= bready_d;
            axi_arvalid <= arvalid_d;
            axi_rready  <= rready_d;
            axi_awaddr  <= awaddr_d;
            axi_wdata   <= wdata_d;
            axi_wstrb   <= wstrb_d;
            axi_araddr  <= araddr_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master. The bench plays the
// AXI slave by hand, cycle by cycle, and checks outputs 1 ns after each
// rising edge.
module tb_axi_lite_master;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    int n_checks = 0;
    int n_errors = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_cnt    = 0;
    int aw_base, w_base, b_base;

    axi_lite_master #(
        .TIMEOUT_CYCLES (16),
        .AXI_PROT       (3'b010)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_rst     (axi_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .rsp_wr      (rsp_wr),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    always #5 axi_clk = ~axi_clk;

    // Count completed handshakes on the write channels.
    always @(posedge axi_clk) begin
        if (axi_awvalid && axi_awready) aw_cnt <= aw_cnt + 1;
        if (axi_wvalid && axi_wready)   w_cnt  <= w_cnt + 1;
        if (axi_bvalid && axi_bready)   b_cnt  <= b_cnt + 1;
    end

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        axi_rst     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_wr      = 1'b0;
        cmd_addr    = 32'h0;
        cmd_wdata   = 32'h0;
        cmd_wstrb   = 4'h0;
        rsp_ready   = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        axi_arready = 1'b0;
        axi_rdata   = 32'h0;
        axi_rresp   = 2'b00;
        axi_rvalid  = 1'b0;

        // ---- reset values ----
        step();
        step();
        check("rst_awvalid", 32'(axi_awvalid), 0);
        check("rst_wvalid",  32'(axi_wvalid),  0);
        check("rst_bready",  32'(axi_bready),  0);
        check("rst_arvalid", 32'(axi_arvalid), 0);
        check("rst_rready",  32'(axi_rready),  0);
        check("rst_awaddr",  axi_awaddr, 0);
        check("rst_wdata",   axi_wdata,  0);
        check("rst_wstrb",   32'(axi_wstrb), 0);
        check("rst_araddr",  axi_araddr, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp",  32'(rsp_resp), 0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 0);
        check("rst_rsp_wr",  32'(rsp_wr), 0);
        check("awprot", 32'(axi_awprot), 32'h2);
        check("arprot", 32'(axi_arprot), 32'h2);
        axi_rst = 1'b0;
        step();
        check("rel_cmd_ready", 32'(cmd_ready), 1);

        // ---- stray B/R responses in IDLE are ignored ----
        axi_bvalid = 1'b1;
        axi_rvalid = 1'b1;
        step();
        check("stray_bready", 32'(axi_bready), 0);
        check("stray_rready", 32'(axi_rready), 0);
        check("stray_rsp_valid", 32'(rsp_valid), 0);
        axi_bvalid = 1'b0;
        axi_rvalid = 1'b0;

        // ---- write, slave readies immediate ----
        aw_base = aw_cnt; w_base = w_cnt; b_base = b_cnt;
        cmd_valid   = 1'b1;
        cmd_wr      = 1'b1;
        cmd_addr    = 32'h0000_0004;
        cmd_wdata   = 32'hDEAD_BEEF;
        cmd_wstrb   = 4'hF;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("w1_awvalid", 32'(axi_awvalid), 1);
        check("w1_wvalid",  32'(axi_wvalid),  1);
        check("w1_awaddr",  axi_awaddr, 32'h0000_0004);
        check("w1_wdata",   axi_wdata,  32'hDEAD_BEEF);
        check("w1_wstrb",   32'(axi_wstrb), 32'hF);
        check("w1_cmd_ready", 32'(cmd_ready), 0);
        step();
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        check("w1_awvalid_drop", 32'(axi_awvalid), 0);
        check("w1_wvalid_drop",  32'(axi_wvalid),  0);
        check("w1_bready", 32'(axi_bready), 1);
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b00;
        step();
        axi_bvalid = 1'b0;
        check("w1_bready_drop", 32'(axi_bready), 0);
        check("w1_rsp_valid", 32'(rsp_valid), 1);
        check("w1_rsp_resp",  32'(rsp_resp), 0);
        check("w1_rsp_timeout", 32'(rsp_timeout), 0);
        check("w1_rsp_wr",    32'(rsp_wr), 1);
        check("w1_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w1_rsp_valid_clr", 32'(rsp_valid), 0);
        check("w1_cmd_ready", 32'(cmd_ready), 1);
        check("w1_aw_count", 32'(aw_cnt - aw_base), 1);
        check("w1_w_count",  32'(w_cnt - w_base), 1);
        check("w1_b_count",  32'(b_cnt - b_base), 1);

        // ---- read with 3-cycle arready delay ----
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0000_0020;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("r1_arvalid_held", 32'(axi_arvalid), 1);
            check("r1_araddr_held",  axi_araddr, 32'h0000_0020);
            check("r1_rready_low",   32'(axi_rready), 0);
            if (i == 3) axi_arready = 1'b1;
            step();
        end
        axi_arready = 1'b0;
        check("r1_arvalid_drop", 32'(axi_arvalid), 0);
        check("r1_rready", 32'(axi_rready), 1);
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h1234_5678;
        axi_rresp  = 2'b00;
        step();
        axi_rvalid = 1'b0;
        axi_rdata  = 32'h0;
        check("r1_rready_drop", 32'(axi_rready), 0);
        check("r1_rsp_valid", 32'(rsp_valid), 1);
        check("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("r1_rsp_resp",  32'(rsp_resp), 0);
        check("r1_rsp_wr",    32'(rsp_wr), 0);
        check("r1_rsp_timeout", 32'(rsp_timeout), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("r1_rsp_valid_clr", 32'(rsp_valid), 0);

        // ---- write, W accepted before AW ----
        aw_base = aw_cnt; w_base = w_cnt; b_base = b_cnt;
        cmd_valid  = 1'b1;
        cmd_wr     = 1'b1;
        cmd_addr   = 32'h0000_0008;
        cmd_wdata  = 32'hA5A5_0001;
        cmd_wstrb  = 4'h3;
        axi_wready = 1'b1;
        step();                                   // N+1
        cmd_valid = 1'b0;
        check("w2_n1_awvalid", 32'(axi_awvalid), 1);
        check("w2_n1_wvalid",  32'(axi_wvalid),  1);
        check("w2_n1_wstrb",   32'(axi_wstrb), 32'h3);
        step();                                   // N+2
        axi_wready = 1'b0;
        check("w2_n2_wvalid_drop", 32'(axi_wvalid), 0);
        check("w2_n2_awvalid", 32'(axi_awvalid), 1);
        check("w2_n2_bready",  32'(axi_bready), 0);
        step();                                   // N+3
        check("w2_n3_awvalid", 32'(axi_awvalid), 1);
        check("w2_n3_wvalid",  32'(axi_wvalid), 0);
        step();                                   // N+4
        check("w2_n4_awvalid", 32'(axi_awvalid), 1);
        check("w2_n4_awaddr",  axi_awaddr, 32'h0000_0008);
        axi_awready = 1'b1;
        step();                                   // N+5
        axi_awready = 1'b0;
        check("w2_awvalid_drop", 32'(axi_awvalid), 0);
        check("w2_bready", 32'(axi_bready), 1);
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b01;
        step();
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        check("w2_rsp_valid", 32'(rsp_valid), 1);
        check("w2_rsp_resp",  32'(rsp_resp), 32'h1);
        check("w2_rsp_timeout", 32'(rsp_timeout), 0);

        // ---- response back-pressure for 5 cycles, new command pending ----
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0000_0030;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_resp",  32'(rsp_resp), 32'h1);
            check("bp_rsp_wr",    32'(rsp_wr), 1);
            check("bp_rsp_rdata", rsp_rdata, 0);
            check("bp_cmd_ready", 32'(cmd_ready), 0);
            check("bp_arvalid",   32'(axi_arvalid), 0);
        end
        check("w2_aw_count", 32'(aw_cnt - aw_base), 1);
        check("w2_w_count",  32'(w_cnt - w_base), 1);
        check("w2_b_count",  32'(b_cnt - b_base), 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_rsp_valid_clr", 32'(rsp_valid), 0);
        check("bp_cmd_ready_back", 32'(cmd_ready), 1);
        check("bp_not_yet_accepted", 32'(axi_arvalid), 0);

        // ---- pending read accepted; slave never answers: timeout ----
        step();                                   // cycle 1 of RD_REQ
        cmd_valid = 1'b0;
        check("to_arvalid_start", 32'(axi_arvalid), 1);
        check("to_araddr", axi_araddr, 32'h0000_0030);
        for (int i = 2; i <= 16; i++) begin
            step();
            check("to_arvalid_held", 32'(axi_arvalid), 1);
            check("to_no_rsp", 32'(rsp_valid), 0);
        end
        step();                                   // cycle 17: aborted
        check("to_arvalid_drop", 32'(axi_arvalid), 0);
        check("to_rready", 32'(axi_rready), 0);
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_timeout", 32'(rsp_timeout), 1);
        check("to_rsp_resp", 32'(rsp_resp), 32'h2);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_rsp_wr", 32'(rsp_wr), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("to_rsp_valid_clr", 32'(rsp_valid), 0);
        check("to_cmd_ready", 32'(cmd_ready), 1);

        // ---- reset asserted in WR_RESP ----
        cmd_valid   = 1'b1;
        cmd_wr      = 1'b1;
        cmd_addr    = 32'h0000_0040;
        cmd_wdata   = 32'hCAFE_F00D;
        cmd_wstrb   = 4'hC;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        check("rw_bready_set", 32'(axi_bready), 1);
        axi_rst = 1'b1;
        step();
        check("rw_bready", 32'(axi_bready), 0);
        check("rw_awvalid", 32'(axi_awvalid), 0);
        check("rw_wvalid", 32'(axi_wvalid), 0);
        check("rw_awaddr", axi_awaddr, 0);
        check("rw_wdata",  axi_wdata, 0);
        check("rw_wstrb",  32'(axi_wstrb), 0);
        check("rw_rsp_valid", 32'(rsp_valid), 0);
        check("rw_rsp_wr", 32'(rsp_wr), 0);
        check("rw_cmd_ready_in_rst", 32'(cmd_ready), 0);
        axi_rst = 1'b0;
        step();
        check("rw_cmd_ready", 32'(cmd_ready), 1);
        check("rw_rsp_valid_after", 32'(rsp_valid), 0);
        check("rw_bready_after", 32'(axi_bready), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
